cpu_reg_file: RTL and testbench
===============================

CPU_REG_FILE -- requirements
Module: cpu_reg_file

Interface
REQ-001 SHALL take parameter SIZE, default 32: register width in bits.
REQ-002 SHALL take parameter NUM_REGS, default 16: register count; legal range 2..256.
REQ-003 SHALL take parameter STEP, default 1: increment/decrement amount, unsigned, less than 2**SIZE.
REQ-004 SHALL use derived localparam SEL_W = $clog2(NUM_REGS).
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-006 SHALL have port rst, input, 1: reset; synchronous, active-high.
REQ-007 SHALL have port a, output tri, SIZE: read bus A.
REQ-008 SHALL have port b, output tri, SIZE: read bus B.
REQ-009 SHALL have ports sel_a and sel_b, input, SEL_W: register selects for buses A and B.
REQ-010 SHALL have ports oe_a and oe_b, input, 1: drive enables for buses A and B.
REQ-011 SHALL have port in, input, SIZE: write data.
REQ-012 SHALL have ports sel_in, input, SEL_W, and ld, input, 1: write select and write strobe.
REQ-013 SHALL have ports sel_cnt, input, SEL_W, inc, input, 1, and dec, input, 1: counter select and step strobes.
REQ-014 SHALL have port value, output logic, NUM_REGS x SIZE: direct register contents, not bused.

Function
REQ-015 SHALL drive a with value[sel_a] when oe_a is 1, otherwise all-Z; combinational, 0-cycle latency.
REQ-016 SHALL apply the same rule to b using sel_b and oe_b; A and B may select the same register.
REQ-017 SHALL, on posedge with ld=1, write in to value[sel_in]; the new value is visible the next cycle.
REQ-018 SHALL, on posedge with inc=1 and dec=0, set value[sel_cnt] to (value[sel_cnt] + STEP) mod 2**SIZE.
REQ-019 SHALL, on posedge with dec=1 and inc=0, set value[sel_cnt] to (value[sel_cnt] - STEP) mod 2**SIZE.
REQ-020 SHALL leave value[sel_cnt] unchanged from the counter path when inc=1 and dec=1.
REQ-021 SHALL let ld win when ld, and inc or dec, target the same register in one cycle; the count is dropped.
REQ-022 SHALL apply ld and inc/dec together when they target different registers in one cycle.
REQ-023 SHALL ignore a select value of NUM_REGS or above (non-power-of-2 NUM_REGS): no write, and a read drives all zeros.
REQ-024 SHALL hold every register unchanged when none of ld, inc or dec applies to it.

Reset
REQ-025 SHALL, on posedge with rst=1, clear every value[i] to 0; rst overrides ld, inc and dec.
REQ-026 SHALL not gate bus drive with rst: during reset, a and b follow REQ-015/016 using the current register contents.

Configuration
REQ-027 SHALL provide the macro CPU_REG_FILE_BYPASS_EN.
REQ-028 SHALL, when CPU_REG_FILE_BYPASS_EN is defined, drive in on a (or b) when ld=1, rst=0 and sel_in equals sel_a (or sel_b), giving same-cycle read-after-write forwarding.
REQ-029 SHALL, when CPU_REG_FILE_BYPASS_EN is undefined, leave reads always returning the registered value; ld and in then have no combinational path to a or b.

Structure
REQ-030 SHALL place the STEP default and an enum type cnt_op_t {CNT_NONE, CNT_INC, CNT_DEC} in package cpu_reg_pkg; the module decodes inc/dec into cnt_op_t.
REQ-031 SHALL use one sub-module, cpu_reg_cell: a single register with ld/inc/dec/rst priority logic, instantiated NUM_REGS times by generate; read muxes and tri-state drivers live in the top module.

Verification
REQ-032 SHALL cover: rst=1 for one cycle after loading 0xDEADBEEF into r3 -> value[3]=0; oe_a=1, sel_a=3 -> a=0x00000000.
REQ-033 SHALL cover: ld r5=0x12345678, next cycle sel_a=5, sel_b=5, oe_a=oe_b=1 -> a=b=0x12345678; then oe_a=0 -> a=Z, b still driven.
REQ-034 SHALL cover: r2=0xFFFFFFFF, inc on r2 (STEP=1) -> r2=0x00000000; dec on r2 -> 0xFFFFFFFF; inc and dec together -> unchanged.
REQ-035 SHALL cover: same cycle ld r7=0x100 and inc r7 -> r7=0x100; same cycle ld r1=0xA and dec r4 (r4 was 0x10) -> r1=0xA, r4=0xF.
REQ-036 SHALL cover: r6=0x55, ld r6=0xAA with sel_a=6, oe_a=1 in that cycle -> a=0xAA with CPU_REG_FILE_BYPASS_EN defined, a=0x55 without.
REQ-037 SHALL cover: NUM_REGS=12, ld with sel_in=13 -> no register changes; sel_a=13, oe_a=1 -> a=0.

Source files
------------

// File: rtl/cpu_reg_pkg.sv
// Shared types and defaults for the CPU register file.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: none.
package cpu_reg_pkg;

  // Default increment/decrement amount applied by the counter path.
  localparam int unsigned STEP_DEFAULT = 1;

  // Counter operation requested for one register in a given cycle.
  typedef enum logic [1:0] {
    CNT_NONE = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_t;

  // inc and dec together cancel, so that case maps to CNT_NONE.
  function automatic cnt_op_t decode_cnt(input logic inc, input logic dec);
    cnt_op_t op;
    op = CNT_NONE;
    if (inc && !dec) op = CNT_INC;
    if (dec && !inc) op = CNT_DEC;
    return op;
  endfunction

endpackage

// File: rtl/cpu_reg_cell.sv
// One register with load / step-counter update; reset > load > count.
// Latency: update visible on q one cycle after the posedge that applies it.
// Backpressure: none; every request is applied on the cycle it is presented.
module cpu_reg_cell
  import cpu_reg_pkg::*;
#(
  parameter int          SIZE = 32,
  parameter int unsigned STEP = STEP_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld,
  input  logic [SIZE-1:0] in,
  input  cnt_op_t         cnt_op,
  output logic [SIZE-1:0] q
);

  // Step truncated to register width; wraps modulo 2**SIZE naturally.
  localparam logic [SIZE-1:0] STEP_V = SIZE'(STEP);

  // Register update: reset wins, then load, then the counter operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (ld) begin
      q <= in;
    end else begin
      case (cnt_op)
        CNT_INC: q <= q + STEP_V;
        CNT_DEC: q <= q - STEP_V;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/cpu_reg_file.sv
// Multi-register file with two tri-state read buses, a write port and a step counter port.
// Latency: reads are combinational (0 cycles); writes/counts visible the next cycle.
// Backpressure: none. Optional same-cycle write forwarding via CPU_REG_FILE_BYPASS_EN.
module cpu_reg_file
  import cpu_reg_pkg::*;
#(
  parameter int          SIZE     = 32,
  parameter int          NUM_REGS = 16,
  parameter int unsigned STEP     = STEP_DEFAULT,
  localparam int         SEL_W    = $clog2(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          rst,
  output tri   [SIZE-1:0]               a,
  output tri   [SIZE-1:0]               b,
  input  logic [SEL_W-1:0]              sel_a,
  input  logic [SEL_W-1:0]              sel_b,
  input  logic                          oe_a,
  input  logic                          oe_b,
  input  logic [SIZE-1:0]               in,
  input  logic [SEL_W-1:0]              sel_in,
  input  logic                          ld,
  input  logic [SEL_W-1:0]              sel_cnt,
  input  logic                          inc,
  input  logic                          dec,
  output logic [NUM_REGS-1:0][SIZE-1:0] value
);

  // Register count widened by one bit so selects can be range-checked
  // without width mismatches when NUM_REGS is not a power of two.
  localparam logic [SEL_W:0] NUM_REGS_W = (SEL_W + 1)'(NUM_REGS);

  cnt_op_t         cnt_op;
  logic            sel_a_ok;
  logic            sel_b_ok;
  logic            sel_in_ok;
  logic [SIZE-1:0] rd_a;
  logic [SIZE-1:0] rd_b;

  // Decode strobes once and range-check every select.
  always_comb begin
    cnt_op    = decode_cnt(inc, dec);
    sel_a_ok  = ({1'b0, sel_a}  < NUM_REGS_W);
    sel_b_ok  = ({1'b0, sel_b}  < NUM_REGS_W);
    sel_in_ok = ({1'b0, sel_in} < NUM_REGS_W);
  end

  // One cell per register; out-of-range selects never match any index.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic    cell_ld;
    cnt_op_t cell_op;

    // Route the write strobe and counter op only to the addressed cell.
    always_comb begin
      cell_ld = ld && (sel_in == SEL_W'(i));
      cell_op = (sel_cnt == SEL_W'(i)) ? cnt_op : CNT_NONE;
    end

    cpu_reg_cell #(
      .SIZE (SIZE),
      .STEP (STEP)
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .ld     (cell_ld),
      .in     (in),
      .cnt_op (cell_op),
      .q      (value[i])
    );
  end

  // Read muxes: registered contents, zero for an out-of-range select.
  // With forwarding, an in-range write to the same register shows through
  // in the same cycle; reset suppresses it because that write is discarded.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (sel_a_ok) rd_a = value[sel_a];
    if (sel_b_ok) rd_b = value[sel_b];
`ifdef CPU_REG_FILE_BYPASS_EN
    if (ld && !rst && sel_in_ok && (sel_in == sel_a)) rd_a = in;
    if (ld && !rst && sel_in_ok && (sel_in == sel_b)) rd_b = in;
`endif
  end

  // Bus drivers release to high impedance when not enabled.
  assign a = oe_a ? rd_a : {SIZE{1'bz}};
  assign b = oe_b ? rd_b : {SIZE{1'bz}};

endmodule

// File: tb/tb_cpu_reg_file.sv
// Scoreboard bench for cpu_reg_file (NUM_REGS=12, SIZE=32, STEP=1).
// Latency: stimulus changes 1 time unit after posedge; monitor samples on negedge.
// Backpressure: none; expectations are queued per cycle and drained by the monitor.
module tb_cpu_reg_file;

  localparam int SIZE     = 32;
  localparam int NUM_REGS = 12;
  localparam int SEL_W    = $clog2(NUM_REGS);

  localparam int K_A   = 0;
  localparam int K_B   = 1;
  localparam int K_VAL = 2;

  localparam logic [31:0] HIZ = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          rst;
  wire  [SIZE-1:0]               a;
  wire  [SIZE-1:0]               b;
  logic [SEL_W-1:0]              sel_a, sel_b, sel_in, sel_cnt;
  logic                          oe_a, oe_b, ld, inc, dec;
  logic [SIZE-1:0]               in;
  logic [NUM_REGS-1:0][SIZE-1:0] value;

  // Released buses float up, so a high-impedance bus reads as all ones.
  pullup pu_a (a);
  pullup pu_b (b);

  cpu_reg_file #(
    .SIZE     (SIZE),
    .NUM_REGS (NUM_REGS),
    .STEP     (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .sel_a   (sel_a),
    .sel_b   (sel_b),
    .oe_a    (oe_a),
    .oe_b    (oe_b),
    .in      (in),
    .sel_in  (sel_in),
    .ld      (ld),
    .sel_cnt (sel_cnt),
    .inc     (inc),
    .dec     (dec),
    .value   (value)
  );

  typedef struct {
    int unsigned cyc;
    int          kind;
    int          idx;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t        sb[$];
  int          n_pass  = 0;
  int          n_total = 0;
  int unsigned cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_chk(input int kind, input int idx, input logic [31:0] exp,
                            input string name);
    chk_t c;
    c.cyc  = cyc;
    c.kind = kind;
    c.idx  = idx;
    c.exp  = exp;
    c.name = name;
    sb.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  chk_t        mon_c;
  logic [31:0] mon_act;

  // Monitor: drain every expectation queued for this cycle and compare.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_c = sb.pop_front();
      case (mon_c.kind)
        K_A:     mon_act = a;
        K_B:     mon_act = b;
        default: mon_act = value[mon_c.idx];
      endcase
      n_total++;
      if (mon_act === mon_c.exp) n_pass++;
      else $display("FAIL %s[%0d]: got %h expected %h", mon_c.name, mon_c.idx,
                    mon_act, mon_c.exp);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [31:0] exp_final [NUM_REGS];
  logic [31:0] byp_exp;

  initial begin
    rst = 1'b1; ld = 1'b0; inc = 1'b0; dec = 1'b0;
    oe_a = 1'b0; oe_b = 1'b0;
    sel_a = '0; sel_b = '0; sel_in = '0; sel_cnt = '0; in = '0;
    tick();
    tick();

    // Reset state: all registers zero, enabled bus reads zero, other bus floats.
    rst = 1'b0; oe_a = 1'b1; sel_a = 4'd0;
    for (int i = 0; i < NUM_REGS; i++) expect_chk(K_VAL, i, 32'h0, "rst_value");
    expect_chk(K_A, 0, 32'h0, "rst_a");
    expect_chk(K_B, 0, HIZ, "rst_b_hiz");

    // Load r3, then reset (with a competing load of r4) while reading r3.
    tick(); oe_a = 1'b0; ld = 1'b1; sel_in = 4'd3; in = 32'hDEAD_BEEF;
    tick(); rst = 1'b1; sel_in = 4'd4; in = 32'h77; sel_a = 4'd3; oe_a = 1'b1;
    expect_chk(K_VAL, 3, 32'hDEAD_BEEF, "ld_r3");
    expect_chk(K_A, 3, 32'hDEAD_BEEF, "a_during_rst");
    tick(); rst = 1'b0; ld = 1'b0;
    expect_chk(K_VAL, 3, 32'h0, "rst_clears_r3");
    expect_chk(K_VAL, 4, 32'h0, "rst_beats_ld_r4");
    expect_chk(K_A, 3, 32'h0, "a_after_rst");

    // Both buses on the same register, then release bus A only.
    tick(); oe_a = 1'b0; ld = 1'b1; sel_in = 4'd5; in = 32'h1234_5678;
    tick(); ld = 1'b0; sel_a = 4'd5; sel_b = 4'd5; oe_a = 1'b1; oe_b = 1'b1;
    expect_chk(K_A, 5, 32'h1234_5678, "a_r5");
    expect_chk(K_B, 5, 32'h1234_5678, "b_r5");
    tick(); oe_a = 1'b0;
    expect_chk(K_A, 5, HIZ, "a_hiz");
    expect_chk(K_B, 5, 32'h1234_5678, "b_still_r5");

    // Counter wrap in both directions and inc+dec cancellation on r2.
    tick(); oe_b = 1'b0; ld = 1'b1; sel_in = 4'd2; in = 32'hFFFF_FFFF;
    tick(); ld = 1'b0; inc = 1'b1; sel_cnt = 4'd2;
    expect_chk(K_VAL, 2, 32'hFFFF_FFFF, "ld_r2");
    tick(); inc = 1'b0; dec = 1'b1;
    expect_chk(K_VAL, 2, 32'h0, "inc_wrap");
    tick(); inc = 1'b1; dec = 1'b1;
    expect_chk(K_VAL, 2, 32'hFFFF_FFFF, "dec_wrap");
    tick(); inc = 1'b0; dec = 1'b0; ld = 1'b1; sel_in = 4'd4; in = 32'h10;
    expect_chk(K_VAL, 2, 32'hFFFF_FFFF, "inc_dec_cancel");

    // Load beats count on the same register; both apply on different ones.
    tick(); sel_in = 4'd7; in = 32'h100; inc = 1'b1; sel_cnt = 4'd7;
    expect_chk(K_VAL, 4, 32'h10, "ld_r4");
    tick(); sel_in = 4'd1; in = 32'hA; inc = 1'b0; dec = 1'b1; sel_cnt = 4'd4;
    expect_chk(K_VAL, 7, 32'h100, "ld_wins_r7");
    tick(); sel_in = 4'd6; in = 32'h55; dec = 1'b0;
    expect_chk(K_VAL, 1, 32'hA, "ld_r1_parallel");
    expect_chk(K_VAL, 4, 32'hF, "dec_r4_parallel");
    expect_chk(K_VAL, 2, 32'hFFFF_FFFF, "r2_held");

    // Read of a register being written in the same cycle.
`ifdef CPU_REG_FILE_BYPASS_EN
    byp_exp = 32'hAA;
`else
    byp_exp = 32'h55;
`endif
    tick(); in = 32'hAA; sel_a = 4'd6; sel_b = 4'd6; oe_a = 1'b1; oe_b = 1'b1;
    expect_chk(K_VAL, 6, 32'h55, "ld_r6");
    expect_chk(K_A, 6, byp_exp, "a_raw_r6");
    expect_chk(K_B, 6, byp_exp, "b_raw_r6");

    // Out-of-range selects: write and count ignored, read drives zero.
    tick(); sel_in = 4'd13; in = 32'hCAFE; sel_a = 4'd13; inc = 1'b1; sel_cnt = 4'd12;
    expect_chk(K_VAL, 6, 32'hAA, "ld_r6_aa");
    expect_chk(K_A, 13, 32'h0, "a_oob_zero");
    expect_chk(K_B, 6, 32'hAA, "b_r6_aa");

    tick(); ld = 1'b0; inc = 1'b0; oe_a = 1'b0; oe_b = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) exp_final[i] = 32'h0;
    exp_final[1] = 32'hA;
    exp_final[2] = 32'hFFFF_FFFF;
    exp_final[4] = 32'hF;
    exp_final[5] = 32'h1234_5678;
    exp_final[6] = 32'hAA;
    exp_final[7] = 32'h100;
    for (int i = 0; i < NUM_REGS; i++) expect_chk(K_VAL, i, exp_final[i], "final_value");

    tick();
    tick();
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      n_total += sb.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
